multicycle_control: RTL and testbench

- Multi-cycle main control FSM for the RV64 subset datapath (R-type, ld, sd, beq); successor to the single-cycle combinational decoder.
- Sequences each instruction through fetch, decode, execute, memory and write-back states, one enable set per cycle.
- Waits on a memory ready handshake, with a timeout.
- Traps on illegal opcodes and keeps a retired-instruction counter.

---
 rtl/multicycle_control.sv | 181 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM for the RV64 subset datapath (R-type, ld, sd, beq).
// Define CTRL_ITYPE_EN to decode opcode 0010011 through EXEC_I; otherwise it traps as illegal.
module multicycle_control #(
  parameter int OPCODE_W = 7,
  parameter int ALUOP_W  = 2,
  parameter int TIMEOUT  = 15,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                pc_source,
  output logic                iord,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALUOP_W-1:0]  aluop,
  output logic                illegal_op,
  output logic                bus_error,
  output logic                instr_done,
  output logic [CNT_W-1:0]    instr_count
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(7'b0110011);
  localparam logic [OPCODE_W-1:0] OP_LD   = OPCODE_W'(7'b0000011);
  localparam logic [OPCODE_W-1:0] OP_SD   = OPCODE_W'(7'b0100011);
  localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(7'b1100011);
`ifdef CTRL_ITYPE_EN
  localparam logic [OPCODE_W-1:0] OP_ITYPE = OPCODE_W'(7'b0010011);
`endif

  localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(2);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_MEM_ADDR,
    S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_TRAP
  } state_t;

  state_t              state, next_state;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                in_wait;
  logic                timeout;
  logic                set_illegal;

  assign in_wait = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  // A ready handshake on the deadline cycle still completes the access.
  assign timeout = in_wait && !mem_ready && (wait_cnt == WAIT_W'(TIMEOUT));

  // NOTE: every output gets a default before the case so no path leaves a latch behind.
  always_comb begin
    next_state    = state;
    set_illegal   = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    aluop         = ALU_ADD;
    instr_done    = 1'b0;

    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          next_state = S_DECODE;
        end else if (timeout) begin
          next_state = S_TRAP;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b10;
        if (opcode == OP_R)                           next_state = S_EXEC_R;
        else if (opcode == OP_LD || opcode == OP_SD)  next_state = S_MEM_ADDR;
        else if (opcode == OP_BEQ)                    next_state = S_BRANCH;
`ifdef CTRL_ITYPE_EN
        else if (opcode == OP_ITYPE)                  next_state = S_EXEC_I;
`endif
        else begin
          next_state  = S_TRAP;
          set_illegal = 1'b1;
        end
      end
      S_EXEC_R: begin
        alu_src_a  = 1'b1;
        aluop      = ALU_FUNCT;
        next_state = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        aluop      = ALU_FUNCT;
        next_state = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        next_state = (opcode == OP_LD) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready)    next_state = S_MEM_WB;
        else if (timeout) next_state = S_TRAP;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          next_state = S_FETCH;
        end else if (timeout) begin
          next_state = S_TRAP;
        end
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        aluop         = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = 1'b1;
        instr_done    = 1'b1;
        next_state    = S_FETCH;
      end
      default: next_state = S_TRAP;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_FETCH;
      wait_cnt    <= '0;
      illegal_op  <= 1'b0;
      bus_error   <= 1'b0;
      instr_count <= '0;
    end else begin
      state <= next_state;
      if (!in_wait || mem_ready || next_state != state) wait_cnt <= '0;
      else                                               wait_cnt <= wait_cnt + 1'b1;
      if (set_illegal) illegal_op <= 1'b1;
      if (timeout)     bus_error  <= 1'b1;
      if (instr_done)  instr_count <= instr_count + 1'b1;
    end
  end

  // zero is consumed by the external PC-write AND-OR gate, not by the sequencer.
  logic unused_zero;
  assign unused_zero = zero;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: each instruction is expanded into the
// per-cycle control words it should produce, given a planned mem_ready stall pattern.
module tb_multicycle_control;

  localparam int TIMEOUT = 15;
  localparam int EFF_NONE = 0, EFF_ILL = 1, EFF_BUS = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  opcode = 7'b0110011;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write;
  logic        ir_write, mem_to_reg, reg_write, alu_src_a;
  logic [1:0]  alu_src_b, aluop;
  logic        illegal_op, bus_error, instr_done;
  logic [31:0] instr_count;

  multicycle_control #(.OPCODE_W(7), .ALUOP_W(2), .TIMEOUT(TIMEOUT), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .aluop(aluop), .illegal_op(illegal_op),
    .bus_error(bus_error), .instr_done(instr_done), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Control word layout: pw pwc ps iord mr mw irw m2r rw asa asb[1:0] aluop[1:0] done
  function automatic logic [14:0] cw(input bit pw, pwc, ps, io, mr, mw, irw, m2r, rw, asa,
                                     input bit [1:0] asb, alu, input bit done);
    return {pw, pwc, ps, io, mr, mw, irw, m2r, rw, asa, asb, alu, done};
  endfunction

  logic [14:0] w_fetch_wait, w_fetch_go, w_decode, w_exec_r, w_exec_i, w_alu_wb, w_mem_addr;
  logic [14:0] w_mem_rd, w_mem_wb, w_mem_wr_wait, w_mem_wr_go, w_branch, w_trap;

  initial begin
    w_fetch_wait  = cw(0,0,0,0,1,0,0,0,0,0,2'b01,2'b00,0);
    w_fetch_go    = cw(1,0,0,0,1,0,1,0,0,0,2'b01,2'b00,0);
    w_decode      = cw(0,0,0,0,0,0,0,0,0,0,2'b10,2'b00,0);
    w_exec_r      = cw(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,0);
    w_exec_i      = cw(0,0,0,0,0,0,0,0,0,1,2'b10,2'b10,0);
    w_alu_wb      = cw(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,1);
    w_mem_addr    = cw(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,0);
    w_mem_rd      = cw(0,0,0,1,1,0,0,0,0,0,2'b00,2'b00,0);
    w_mem_wb      = cw(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,1);
    w_mem_wr_wait = cw(0,0,0,1,0,1,0,0,0,0,2'b00,2'b00,0);
    w_mem_wr_go   = cw(0,0,0,1,0,1,0,0,0,0,2'b00,2'b00,1);
    w_branch      = cw(0,1,1,0,0,0,0,0,0,1,2'b00,2'b01,1);
    w_trap        = '0;
  end

  typedef struct {
    logic [14:0] w;
    bit          rdy;
    int          eff;
  } step_t;

  step_t       plan[$];
  logic [31:0] exp_count = '0;
  bit          exp_ill = 1'b0;
  bit          exp_bus = 1'b0;

  function automatic void add(input logic [14:0] w, input bit rdy, input int eff);
    step_t s;
    s.w = w; s.rdy = rdy; s.eff = eff;
    plan.push_back(s);
  endfunction

  // Memory handshake phase: up to TIMEOUT low cycles are tolerated, one more is a bus error.
  function automatic bit add_mem_phase(input logic [14:0] wait_w, input logic [14:0] go_w,
                                       input int stalls);
    if (stalls > TIMEOUT) begin
      for (int i = 0; i < TIMEOUT; i++) add(wait_w, 1'b0, EFF_NONE);
      add(wait_w, 1'b0, EFF_BUS);
      return 1'b1;
    end
    for (int i = 0; i < stalls; i++) add(wait_w, 1'b0, EFF_NONE);
    add(go_w, 1'b1, EFF_NONE);
    return 1'b0;
  endfunction

  function automatic bit itype_legal();
`ifdef CTRL_ITYPE_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Reset is released by the next instruction's first cycle, so it spans `cycles` edges.
  task automatic assert_reset(input int cycles);
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b0;
    for (int i = 1; i < cycles; i++) @(negedge clk);
    exp_count = '0;
    exp_ill = 1'b0;
    exp_bus = 1'b0;
  endtask

  // abort_at >= 0 asserts reset in place of that step.
  task automatic run_instr(input logic [6:0] op, input int sf, input int sm, input int abort_at);
    bit trapped;
    plan.delete();
    trapped = add_mem_phase(w_fetch_wait, w_fetch_go, sf);
    if (!trapped) begin
      bit r0 = 1'($urandom);
      if (op == 7'b0110011) begin
        add(w_decode, r0, EFF_NONE);
        add(w_exec_r, 1'($urandom), EFF_NONE);
        add(w_alu_wb, 1'($urandom), EFF_NONE);
      end else if (op == 7'b0010011 && itype_legal()) begin
        add(w_decode, r0, EFF_NONE);
        add(w_exec_i, 1'($urandom), EFF_NONE);
        add(w_alu_wb, 1'($urandom), EFF_NONE);
      end else if (op == 7'b0000011) begin
        add(w_decode, r0, EFF_NONE);
        add(w_mem_addr, 1'($urandom), EFF_NONE);
        trapped = add_mem_phase(w_mem_rd, w_mem_rd, sm);
        if (!trapped) add(w_mem_wb, 1'($urandom), EFF_NONE);
      end else if (op == 7'b0100011) begin
        add(w_decode, r0, EFF_NONE);
        add(w_mem_addr, 1'($urandom), EFF_NONE);
        trapped = add_mem_phase(w_mem_wr_wait, w_mem_wr_go, sm);
      end else if (op == 7'b1100011) begin
        add(w_decode, r0, EFF_NONE);
        add(w_branch, 1'($urandom), EFF_NONE);
      end else begin
        add(w_decode, r0, EFF_ILL);
        trapped = 1'b1;
      end
    end
    if (trapped) for (int i = 0; i < 3; i++) add(w_trap, 1'($urandom), EFF_NONE);

    opcode = op;
    foreach (plan[i]) begin
      if (i == abort_at) begin
        assert_reset(1);
        return;
      end
      @(negedge clk);
      reset = 1'b0;
      mem_ready = plan[i].rdy;
      zero = 1'($urandom);
      #1;
      check("ctrl_word", 32'({pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write,
                              ir_write, mem_to_reg, reg_write, alu_src_a, alu_src_b, aluop,
                              instr_done}), 32'(plan[i].w));
      check("illegal_op", 32'(illegal_op), 32'(exp_ill));
      check("bus_error", 32'(bus_error), 32'(exp_bus));
      check("instr_count", instr_count, exp_count);
      if (plan[i].w[0]) exp_count++;
      if (plan[i].eff == EFF_ILL) exp_ill = 1'b1;
      if (plan[i].eff == EFF_BUS) exp_bus = 1'b1;
    end
    if (trapped) assert_reset(2);
  endtask

  function automatic logic [6:0] pick_opcode();
    logic [6:0] legal[6];
    legal = '{7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0010011, 7'b1111111};
    if ($urandom_range(0, 9) == 0) return 7'($urandom);
    return legal[$urandom_range(0, 5)];
  endfunction

  function automatic int pick_stall();
    case ($urandom_range(0, 19))
      0:       return TIMEOUT;
      1:       return TIMEOUT + 1;
      default: return $urandom_range(0, 3);
    endcase
  endfunction

  initial begin
    assert_reset(2);
    run_instr(7'b0110011, 0, 0, -1);            // R-type, 4 cycles
    run_instr(7'b0000011, 0, 3, -1);            // ld with 3 stall cycles, 8 cycles
    run_instr(7'b1100011, 0, 0, -1);            // beq
    run_instr(7'b1100011, 0, 0, -1);
    run_instr(7'b0100011, 0, TIMEOUT, -1);      // handshake on the deadline cycle wins
    run_instr(7'b0100011, 0, TIMEOUT + 1, -1);  // sd timeout -> bus_error, trap, reset
    run_instr(7'b0110011, TIMEOUT + 1, 0, -1);  // fetch timeout
    run_instr(7'b1111111, 0, 0, -1);            // illegal opcode
    run_instr(7'b0010011, 0, 0, -1);            // I-type: trap or 4-cycle retire
    run_instr(7'b0100011, 0, 3, 4);             // reset mid MEM_WR
    run_instr(7'b0110011, 0, 0, -1);            // restarts from FETCH with count 0
    for (int n = 0; n < 150; n++)
      run_instr(pick_opcode(), pick_stall(), pick_stall(), ($urandom_range(0, 15) == 0) ?
                int'($urandom_range(0, 5)) : -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
